// File: rtl/debounce_edge.sv
// debounce_edge: glitch filter for a registered single-bit input.
// The debounced level changes only after din has held a new value for
// STABLE_CYCLES consecutive rising edges. Accepted transitions produce
// one-cycle rise/fall pulses, and accepted rises are counted modulo 2^PCNT_W.
// Every output comes straight from a flop, so no output depends
// combinationally on din.
module debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8,
  parameter int PCNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic              level,
  output logic              rise,
  output logic              fall,
  output logic              busy,
  output logic [PCNT_W-1:0] press_cnt
);

  // Reject illegal parameterisations at elaboration time.
  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
    $error("debounce_edge: STABLE_CYCLES must be in 2..255");
  end
  if ((64'd1 << CNT_W) <= 64'(STABLE_CYCLES)) begin : g_bad_cnt_w
    $error("debounce_edge: CNT_W too narrow for STABLE_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  // The candidate value is accepted on the sample where cnt already holds
  // STABLE_CYCLES-1, which makes that sample the STABLE_CYCLES-th in the run.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                busy_q, busy_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;

  // State and output registers; asynchronous clear to the IDLE_LO state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so that every flop samples the
      // pre-edge values, whatever order these lines happen to be in.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Next-state logic: qualify a candidate level, then accept it or drop it.
  always_comb begin
    // NOTE: every signal gets a default before the case statement. A path
    // that skipped an assignment would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    pcnt_d  = pcnt_q;

    unique case (state_q)
      IDLE_LO: begin
        if (din) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!din) begin
          state_d = IDLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
          pcnt_d  = pcnt_q + PCNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!din) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (din) begin
          state_d = IDLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
      end
    endcase

    busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
  end

  assign level     = level_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign busy      = busy_q;
  assign press_cnt = pcnt_q;

endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge: directed and randomized stimulus for debounce_edge,
// compared against a run-length reference model.
module tb_debounce_edge;

  localparam int STABLE = 4;
  localparam int PCNT_W = 8;

  logic              clk;
  logic              rst;
  logic              din;
  logic              level;
  logic              rise;
  logic              fall;
  logic              busy;
  logic [PCNT_W-1:0] press_cnt;

  int tests_run;
  int tests_failed;

  // Reference model: the number of consecutive samples that differ from the
  // debounced level. The level flips once that run reaches STABLE.
  logic              m_level;
  logic              m_rise;
  logic              m_fall;
  logic              m_busy;
  logic [PCNT_W-1:0] m_pcnt;
  int                m_run;
  int                rise_seen;

  debounce_edge #(
    .STABLE_CYCLES(STABLE),
    .CNT_W(8),
    .PCNT_W(PCNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .level(level),
    .rise(rise),
    .fall(fall),
    .busy(busy),
    .press_cnt(press_cnt)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_level = 1'b0;
    m_rise  = 1'b0;
    m_fall  = 1'b0;
    m_busy  = 1'b0;
    m_pcnt  = '0;
    m_run   = 0;
  endtask

  task automatic model_sample(input logic d);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (d != m_level) begin
      m_run++;
      if (m_run == STABLE) begin
        m_level = d;
        m_run   = 0;
        if (d) begin
          m_rise = 1'b1;
          m_pcnt = m_pcnt + 1'b1;
        end else begin
          m_fall = 1'b1;
        end
      end
    end else begin
      m_run = 0;
    end
    m_busy = (m_run != 0);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".level"}, 32'(level), 32'(m_level));
    check({tag, ".rise"},  32'(rise),  32'(m_rise));
    check({tag, ".fall"},  32'(fall),  32'(m_fall));
    check({tag, ".busy"},  32'(busy),  32'(m_busy));
    check({tag, ".pcnt"},  32'(press_cnt), 32'(m_pcnt));
  endtask

  // Drive din at the falling edge, let one rising edge sample it, then
  // compare every output 1 time unit after that edge.
  task automatic step(input logic d, input string tag);
    din = d;
    @(posedge clk);
    model_sample(d);
    if (m_rise) rise_seen++;
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic steps(input logic d, input int n, input string tag);
    for (int i = 0; i < n; i++) step(d, tag);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rise_seen    = 0;
    model_reset();
    rst = 1'b1;
    din = 1'b1;

    // Asynchronous reset: outputs must clear before any clock edge.
    #10;
    rst = 1'b0;
    #1;
    check_all("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_hold");
    @(negedge clk);
    rst = 1'b1;

    // Clean press: busy after edge 1, accepted on edge 4, pulse gone on edge 5.
    step(1'b1, "press_e1");
    check("press_e1_busy", 32'(busy), 32'd1);
    steps(1'b1, 2, "press_e23");
    step(1'b1, "press_e4");
    check("press_e4_level", 32'(level), 32'd1);
    check("press_e4_rise", 32'(rise), 32'd1);
    check("press_e4_pcnt", 32'(press_cnt), 32'd1);
    step(1'b1, "press_e5");
    check("press_e5_rise", 32'(rise), 32'd0);
    step(1'b1, "press_e6");

    // Release: fall on the 4th low edge, for exactly one cycle.
    steps(1'b0, 3, "release_e123");
    step(1'b0, "release_e4");
    check("release_fall", 32'(fall), 32'd1);
    check("release_level", 32'(level), 32'd0);
    check("release_pcnt", 32'(press_cnt), 32'd1);
    step(1'b0, "release_e5");
    check("release_fall_clr", 32'(fall), 32'd0);

    // Glitch rejection: 3 high samples, then low.
    steps(1'b1, 3, "glitch_hi");
    step(1'b0, "glitch_end");
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_level", 32'(level), 32'd0);
    check("glitch_pcnt", 32'(press_cnt), 32'd1);

    // Wrap: reset, then 256 presses of 4 high / 4 low.
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_all("wrap_reset");
    @(negedge clk);
    rst = 1'b1;
    rise_seen = 0;
    for (int p = 1; p <= 256; p++) begin
      steps(1'b1, STABLE, "wrap_hi");
      if (p == 255) check("wrap_pcnt_255", 32'(press_cnt), 32'd255);
      if (p == 256) check("wrap_pcnt_0", 32'(press_cnt), 32'd0);
      steps(1'b0, STABLE, "wrap_lo");
    end
    check("wrap_rise_count", 32'(rise_seen), 32'd256);

    // Reset in the middle of WAIT_HI: the candidate is discarded and must
    // re-qualify for a full STABLE run after deassertion.
    steps(1'b1, 2, "midrst_pre");
    check("midrst_pre_busy", 32'(busy), 32'd1);
    #10;
    rst = 1'b0;
    #1;
    model_reset();
    check("midrst_busy", 32'(busy), 32'd0);
    check_all("midrst_async");
    @(posedge clk);
    #1;
    check_all("midrst_hold");
    @(negedge clk);
    rst = 1'b1;
    rise_seen = 0;
    steps(1'b1, STABLE - 1, "midrst_requal");
    check("midrst_level_early", 32'(level), 32'd0);
    step(1'b1, "midrst_accept");
    check("midrst_level", 32'(level), 32'd1);
    steps(1'b1, 3, "midrst_hold_hi");
    check("midrst_single_rise", 32'(rise_seen), 32'd1);

    // Randomized runs of random length, with short glitches mixed in.
    for (int r = 0; r < 300; r++) begin
      logic d;
      int   len;
      d   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 2 * STABLE));
      steps(d, len, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit so that a hung run still ends with a report.
  initial begin
    #(100 * 20000);
    $display("FAIL timeout observed=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/debounce_edge.md
Name: debounce_edge

Overview:
- Consumes the registered single-bit output of the team's D flip-flop stage (its Q drives `din`).
- Filters glitches: the output level changes only after `din` has held a new value for STABLE_CYCLES consecutive clock edges.
- Emits one-cycle rise/fall pulses and keeps a wrapping count of accepted rising edges.
- Sits between the input-register flop and downstream control logic.

Parameters:
- STABLE_CYCLES, 4: consecutive samples of a new value required before `level` changes. Legal range is 2..255; elaboration fails outside it.
- CNT_W, 8: width of the internal stability counter. Must satisfy 2^CNT_W > STABLE_CYCLES.
- PCNT_W, 8: width of `press_cnt`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Assertion (0) clears all state immediately. Deassertion is expected synchronous to clk.
- din  input  1  registered input bit from the upstream flip-flop stage.
- level  output  1  debounced level.
- rise  output  1  one-cycle pulse when `level` goes 0->1.
- fall  output  1  one-cycle pulse when `level` goes 1->0.
- busy  output  1  high while a candidate transition is being qualified (WAIT_HI or WAIT_LO).
- press_cnt  output  PCNT_W  count of accepted rising edges, wraps modulo 2^PCNT_W.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE_LO, cnt=0.
  - level=0, rise=0, fall=0, busy=0, press_cnt=0.
  - Takes effect without a clock edge and holds while rst=0.
- All outputs are registered; there are no combinational paths from `din` to any output.
- FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO. `busy`=1 exactly in WAIT_HI and WAIT_LO.
- IDLE_LO:
  - din=1: go to WAIT_HI, cnt<=1.
  - din=0: stay, cnt<=0.
- WAIT_HI:
  - din=0: go to IDLE_LO, cnt<=0. No pulse.
  - din=1 and cnt==STABLE_CYCLES-1: go to IDLE_HI, level<=1, rise<=1, press_cnt<=press_cnt+1, cnt<=0.
  - din=1 otherwise: cnt<=cnt+1.
- IDLE_HI and WAIT_LO mirror IDLE_LO and WAIT_HI with polarity inverted. Acceptance sets level<=0 and fall<=1; press_cnt is unchanged.
- Latency: `level` and the pulse update on the STABLE_CYCLES-th consecutive rising edge that samples the new value. Example: `din` sampled 1 at edges k..k+3 with STABLE_CYCLES=4 gives level=1 and rise=1 after edge k+3.
- `rise` and `fall` are high for exactly one clock, cleared on the following edge. They are never high simultaneously.
- press_cnt wrap: all-ones + 1 = 0. No saturation, no flag.
- Back-to-back transitions: after acceptance the FSM is in IDLE_x. A new candidate can start on the next edge, so the minimum spacing between a rise and a fall pulse is STABLE_CYCLES clocks.
- A glitch shorter than STABLE_CYCLES samples produces no pulse and no level change. `busy` returns to 0 on the edge after the glitch ends.
- Reset mid-qualification (WAIT_x): the candidate is discarded. After deassertion the block starts in IDLE_LO regardless of `din`. If din=1 at that point, it must re-qualify for a full STABLE_CYCLES.
- `din` at X/Z is not legal. The bench must drive `din` to a known value from time 0.

Test Plan:
- Reset: rst=0 for 2 cycles with din=1 -> level=0, rise=0, fall=0, busy=0, press_cnt=0. All are 0 immediately on rst falling, before any clk edge.
- Clean press, STABLE_CYCLES=4, clk period 100: rst=1, din=1 held 6 cycles -> busy=1 after edge 1; level=1, rise=1 and press_cnt=1 after edge 4; rise=0 after edge 5.
- Glitch rejection: from IDLE_LO, din=1 for 3 cycles then 0 -> level stays 0, no rise, press_cnt unchanged, busy=0 one edge after din drops.
- Release: from level=1, din=0 held 4 cycles -> level=0 and fall=1 after the 4th edge, for exactly one cycle; press_cnt unchanged.
- Wrap: drive 256 accepted presses (each 4 high / 4 low cycles) -> press_cnt reads 255 after the 255th and 0 after the 256th; rise pulses 256 times.
- Reset mid-WAIT_HI: din=1 for 2 cycles, pulse rst=0 for 1 cycle, keep din=1 -> busy=0 during reset. level=1 only after 4 full edges post-deassertion, with a single rise pulse.
